// File: rtl/tft_spi_tx.sv
// tft_spi_tx: byte-level SPI mode-0 transmitter for an ILI9341-class TFT panel.
// Accepts one byte plus D/C flag per tft_transmit pulse while tft_busy is low,
// shifts it out MSB first, and owns the panel hardware-reset sequence after rst.
module tft_spi_tx #(
    parameter int CLK_DIV         = 2,
    parameter int RST_LOW_CYCLES  = 500,
    parameter int RST_WAIT_CYCLES = 6000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tft_transmit,
    input  logic       tft_dc,
    input  logic [7:0] tft_data,
    output logic       tft_busy,
    output logic       spi_cs_n,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       spi_dc,
    output logic       tft_rst_n
);

    localparam int CNT_MAX_A = (RST_WAIT_CYCLES > CLK_DIV) ? RST_WAIT_CYCLES : CLK_DIV;
    localparam int CNT_MAX   = (RST_LOW_CYCLES > CNT_MAX_A) ? RST_LOW_CYCLES : CNT_MAX_A;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LOW_LAST  = CW'(RST_LOW_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(RST_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        RST_LOW,
        RST_WAIT,
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic            cnt_last;
    logic            sck_hi;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            dc_reg;

    // Terminal count of the per-state delay counter.
    always_comb begin
        cnt_last = 1'b0;
        case (state)
            RST_LOW:            cnt_last = (cnt == LOW_LAST);
            RST_WAIT:           cnt_last = (cnt == WAIT_LAST);
            SETUP, SHIFT, HOLD: cnt_last = (cnt == DIV_LAST);
            default:            cnt_last = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= RST_LOW;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            RST_LOW:  if (cnt_last) state_next = RST_WAIT;
            RST_WAIT: if (cnt_last) state_next = IDLE;
            IDLE:     if (tft_transmit) state_next = SETUP;
            SETUP:    if (cnt_last) state_next = SHIFT;
            SHIFT:    if (cnt_last && sck_hi && (bit_idx == 3'd7)) state_next = HOLD;
            HOLD:     if (cnt_last) state_next = IDLE;
            default:  state_next = RST_LOW;
        endcase
    end

    // Delay counter, SCK phase, bit index and the latched byte / D/C flag.
    // The next bit is shifted onto MOSI on the same edge SCK drops, so MOSI
    // only ever changes while SCK is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            sck_hi  <= 1'b0;
            bit_idx <= '0;
            shreg   <= '0;
            dc_reg  <= 1'b0;
        end else begin
            if ((state_next != state) || cnt_last)
                cnt <= '0;
            else if (state != IDLE)
                cnt <= cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (tft_transmit) begin
                        shreg   <= tft_data;
                        dc_reg  <= tft_dc;
                        bit_idx <= '0;
                        sck_hi  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt_last) begin
                        sck_hi <= ~sck_hi;
                        if (sck_hi && (bit_idx != 3'd7)) begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {shreg[6:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and datapath registers.
    always_comb begin
        tft_busy  = (state != IDLE);
        spi_cs_n  = !((state == SETUP) || (state == SHIFT) || (state == HOLD));
        spi_sck   = (state == SHIFT) && sck_hi;
        spi_mosi  = shreg[7];
        spi_dc    = dc_reg;
        tft_rst_n = (state != RST_LOW);
    end

endmodule
